// File: rtl/dmem_port.sv
// dmem_port: core data-memory port with a memory-mapped output stream.
//
// Purpose
//   The core sees one byte-addressed load/store port. The low region
//   (ramaddress < 4*DEPTH) is a word RAM. A store to OUT_ADDR pushes the
//   store data into a FIFO_DEPTH-entry stream FIFO that drains through a
//   valid/ready sink interface. All other addresses are unmapped: they
//   read as zero and ignore stores.
//
// Optional feature (macro DMEM_STATUS_EN)
//   When defined, OUT_ADDR+4 becomes a status register. A load returns
//   {overflow, zero pad, count}, and any store to it clears overflow.
//   When undefined, OUT_ADDR+4 is plain unmapped space and overflow
//   clears only on reset.
//
// Ports
//   clock        in   rising-edge clock
//   nreset       in   asynchronous active-low reset
//   writeram     in   store strobe (one store per rising edge while high)
//   ramaddress   in   WIDTH-bit byte address for loads and stores
//   writeramdata in   WIDTH-bit store data
//   readramdata  out  registered load data (one-cycle latency, read-first)
//   out_data     out  stream FIFO head word
//   out_valid    out  stream FIFO non-empty
//   out_ready    in   sink accepts the head word
//   overflow     out  sticky flag: a push was dropped because the FIFO was full
//
// Stream handshake: a word transfers on every rising edge where
// out_valid && out_ready. out_valid depends only on registered FIFO
// state, never on out_ready, and once raised it stays high with out_data
// stable until that word is taken (or reset flushes the FIFO).

module dmem_port #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       DEPTH      = 1024,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter logic [WIDTH-1:0]  OUT_ADDR   = 32'hFFFF_FF00
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             writeram,
    input  logic [WIDTH-1:0] ramaddress,
    input  logic [WIDTH-1:0] writeramdata,
    output logic [WIDTH-1:0] readramdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);

    localparam int unsigned      AW        = $clog2(DEPTH);
    localparam int unsigned      FW        = $clog2(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] RAM_LIMIT = WIDTH'(4 * DEPTH);
    localparam logic [FW:0]      CNT_FULL  = (FW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          ram_sel;
    logic          push_sel;
    logic [AW-1:0] word_idx;

    assign ram_sel  = (ramaddress < RAM_LIMIT);
    assign push_sel = (ramaddress == OUT_ADDR);
    // Byte offset bits [1:0] are ignored.
    assign word_idx = ramaddress[AW+1:2];

    // ------------------------------------------------------------------
    // Data RAM (no reset, so it maps onto block memory)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (writeram && ram_sel) begin
            mem[word_idx] <= writeramdata;
        end
    end

    // ------------------------------------------------------------------
    // Stream FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW:0]      count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic push_req;
    logic pop;
    logic fifo_full;
    logic push_ok;
    logic push_drop;

    assign push_req  = writeram && push_sel;
    assign pop       = (count_q != '0) && out_ready;
    assign fifo_full = (count_q == CNT_FULL);
    // A same-cycle pop frees the slot a push into a full FIFO needs.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= writeramdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are FW bits wide, so the increments wrap modulo FIFO_DEPTH.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (FW + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (FW + 1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag and optional status register
    // ------------------------------------------------------------------
`ifdef DMEM_STATUS_EN
    logic             stat_sel;
    logic [WIDTH-1:0] status_word;

    assign stat_sel = (ramaddress == (OUT_ADDR + WIDTH'(4)));

    always_comb begin
        status_word            = '0;
        status_word[WIDTH-1]   = overflow_q;
        status_word[FW:0]      = count_q;
    end

    always_comb begin
        overflow_d = overflow_q;
        if (writeram && stat_sel) begin
            overflow_d = 1'b0;
        end
        // A dropped push in the same cycle as a clear keeps the flag set.
        if (push_drop) begin
            overflow_d = 1'b1;
        end
    end
`else
    always_comb begin
        overflow_d = overflow_q | push_drop;
    end
`endif

    // ------------------------------------------------------------------
    // Load data: registered every cycle; RAM read sees pre-write contents
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] readramdata_q, readramdata_d;

    always_comb begin
        readramdata_d = '0;
        if (ram_sel) begin
            readramdata_d = mem[word_idx];
        end
`ifdef DMEM_STATUS_EN
        else if (stat_sel) begin
            readramdata_d = status_word;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            readramdata_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            readramdata_q <= readramdata_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign readramdata = readramdata_q;
    assign out_data    = fifo_mem[rd_ptr_q];
    assign out_valid   = (count_q != '0);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed plus randomized checks of dmem_port against a
// queue/array reference model. Status-register checks compile in only
// when DMEM_STATUS_EN is defined.

module tb_dmem_port;

    localparam int unsigned  DEPTH    = 1024;
    localparam int unsigned  FDEPTH   = 16;
    localparam logic [31:0]  OUT_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0]  STAT_ADDR = OUT_ADDR + 32'd4;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clock;
    logic        nreset;
    logic        writeram;
    logic [31:0] ramaddress;
    logic [31:0] writeramdata;
    logic [31:0] readramdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    dmem_port #(
        .WIDTH      (32),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FDEPTH),
        .OUT_ADDR   (OUT_ADDR)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .writeram     (writeram),
        .ramaddress   (ramaddress),
        .writeramdata (writeramdata),
        .readramdata  (readramdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];           // expected stream words, head first
    logic [31:0] ram_m  [DEPTH];
    bit          ram_ok [DEPTH];     // word has been written since time 0
    bit          ovf_m;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // What a load of addr should return, computed from the current model.
    task automatic model_read(input logic [31:0] addr, output bit known, output logic [31:0] val);
        int idx;
        known = 1'b1;
        val   = 32'h0;
        if (addr < 4 * DEPTH) begin
            idx   = int'(addr / 4);
            known = ram_ok[idx];
            val   = ram_m[idx];
        end
`ifdef DMEM_STATUS_EN
        else if (addr == STAT_ADDR) begin
            val = (ovf_m ? 32'h8000_0000 : 32'h0) + 32'(exp_q.size());
        end
`endif
    endtask

    // One clock cycle: check the pre-edge stream outputs, apply inputs,
    // advance the model, then check the load result after the edge.
    task automatic cycle(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdy);
        bit          known;
        logic [31:0] exp_rd;
        bit          pop;
        bit          full;
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
        model_read(addr, known, exp_rd);

        writeram     = we;
        ramaddress   = addr;
        writeramdata = data;
        out_ready    = rdy;

        pop  = (exp_q.size() != 0) && rdy;
        full = (exp_q.size() == FDEPTH);
        if (pop) void'(exp_q.pop_front());
        if (we && addr == OUT_ADDR) begin
            if (full && !pop) ovf_m = 1'b1;
            else exp_q.push_back(data);
        end
        if (we && addr < 4 * DEPTH) begin
            ram_m[addr / 4]  = data;
            ram_ok[addr / 4] = 1'b1;
        end
`ifdef DMEM_STATUS_EN
        if (we && addr == STAT_ADDR && !(we && addr == OUT_ADDR && full && !pop)) ovf_m = 1'b0;
`endif

        @(posedge clock);
        #1;
        if (known) chk("readramdata", readramdata, exp_rd);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0000_8000, 32'h0, rdy);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        int          op;
        vectors     = 0;
        miscompares = 0;
        ovf_m       = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram_ok[i] = 1'b0;

        nreset       = 1'b0;
        writeram     = 1'b0;
        ramaddress   = 32'h0;
        writeramdata = 32'h0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_readramdata", readramdata, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_overflow", {31'b0, overflow}, 32'h0);
        @(negedge clock);
        nreset = 1'b1;

        // Store then load next cycle.
        cycle(1'b1, 32'h10, 32'h1234_5678, 1'b0);
        cycle(1'b0, 32'h10, 32'h0, 1'b0);
        chk("load_0x10", readramdata, 32'h1234_5678);

        // Read-during-write returns the old word; byte offset ignored.
        cycle(1'b1, 32'h20, 32'h5, 1'b0);
        cycle(1'b1, 32'h20, 32'hAAAA_0000, 1'b0);
        chk("rdw_old", readramdata, 32'h5);
        cycle(1'b0, 32'h23, 32'h0, 1'b0);
        chk("rdw_new", readramdata, 32'hAAAA_0000);

        // Unmapped stores ignored, unmapped loads read zero.
        cycle(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 32'h0000_5000, 32'h0, 1'b0);
        cycle(1'b0, OUT_ADDR, 32'h0, 1'b0);
        cycle(1'b0, STAT_ADDR, 32'h0, 1'b0);
        cycle(1'b0, 32'h0000_0FFC, 32'h0, 1'b0);

        // Full FIFO with a same-cycle pop accepts the push.
        for (int i = 1; i <= 16; i++) cycle(1'b1, OUT_ADDR, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, OUT_ADDR, 32'h99, 1'b1);
        chk("full_pop_push_ovf", {31'b0, overflow}, 32'h0);
        for (int i = 0; i < 16; i++) idle(1'b1);
        idle(1'b0);

        // Overflow on push while full, then drain 1..16.
        for (int i = 1; i <= 16; i++) cycle(1'b1, OUT_ADDR, 32'(i), 1'b0);
        cycle(1'b1, OUT_ADDR, 32'd17, 1'b0);
        chk("overflow_set", {31'b0, overflow}, 32'h1);
        for (int i = 0; i < 16; i++) idle(1'b1);
        idle(1'b1);
        chk("drained", {31'b0, out_valid}, 32'h0);

`ifdef DMEM_STATUS_EN
        for (int i = 0; i < 3; i++) cycle(1'b1, OUT_ADDR, 32'h40 + 32'(i), 1'b0);
        cycle(1'b0, STAT_ADDR, 32'h0, 1'b0);
        chk("status_ovf", readramdata, 32'h8000_0003);
        cycle(1'b1, STAT_ADDR, 32'h0, 1'b0);
        cycle(1'b0, STAT_ADDR, 32'h0, 1'b0);
        chk("status_clr", readramdata, 32'h0000_0003);
        for (int i = 0; i < 3; i++) idle(1'b1);
`endif

        // Reset mid-operation with 5 words queued.
        for (int i = 0; i < 5; i++) cycle(1'b1, OUT_ADDR, 32'h500 + 32'(i), 1'b0);
        cycle(1'b0, 32'h10, 32'h0, 1'b0);
        #3;
        nreset = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_rdata", readramdata, 32'h0);
        chk("async_rst_ovf", {31'b0, overflow}, 32'h0);
        exp_q.delete();
        ovf_m = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        nreset = 1'b1;
        cycle(1'b0, 32'h10, 32'h0, 1'b1);
        chk("ram_kept", readramdata, 32'h1234_5678);
        idle(1'b1);

        // Randomized mix of stores, pushes, status writes and loads.
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    a = 32'($urandom_range(0, 255));
                    cycle(1'b1, a, $urandom, 1'($urandom_range(0, 1)));
                end
                3, 4, 5: cycle(1'b1, OUT_ADDR, $urandom, 1'($urandom_range(0, 3) == 0));
                6:       cycle(1'b1, STAT_ADDR, $urandom, 1'($urandom_range(0, 1)));
                7:       cycle(1'b1, 32'h0001_0000 + 32'($urandom_range(0, 255)), $urandom, 1'b1);
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = OUT_ADDR;
                        1:       a = STAT_ADDR;
                        default: a = 32'($urandom_range(0, 255));
                    endcase
                    cycle(1'b0, a, 32'h0, 1'($urandom_range(0, 2) != 0));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
